// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA geometry, text grid, command codes and pixel values
package vga_pkg;

  localparam int H_PIX  = 640;
  localparam int V_PIX  = 400;
  localparam int CHAR_W = 8;
  localparam int CHAR_H = 8;

  localparam logic [6:0] COLS = 7'd80;
  localparam logic [5:0] ROWS = 6'd50;

  localparam logic [7:0] FONT_FIRST = 8'h20;
  localparam int         FONT_NUM   = 96;

  localparam logic [7:0] FG = 8'hff;
  localparam logic [7:0] BG = 8'h00;

  // 640x400 @ 70 Hz sync timing, consumed by the scan-out timing generator
  localparam int H_FRONT = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BACK  = 48;
  localparam int V_FRONT = 12;
  localparam int V_SYNC  = 2;
  localparam int V_BACK  = 35;

  typedef enum logic [1:0] {
    OP_PUTC_AT  = 2'b00,
    OP_PUTC_CUR = 2'b01,
    OP_NEWLINE  = 2'b10,
    OP_CLEAR    = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_DRAW,
    ST_DONE,
    ST_CLR
  } state_e;

endpackage

// File: rtl/vga_char_addr.sv
// rtl/vga_char_addr.sv - text cell (col,row) to framebuffer base address
module vga_char_addr
  import vga_pkg::*;
(
  input  logic [6:0]  i_col,
  input  logic [5:0]  i_row,
  output logic [17:0] o_base
);

  // row*5120 + col*8 as shifts: 5120 = 4096 + 1024, no multiplier needed
  assign o_base = {i_row, 12'd0} + {2'd0, i_row, 10'd0} + {8'd0, i_col, 3'd0};

endmodule

// File: rtl/vga_text_ctrl.sv
// rtl/vga_text_ctrl.sv - command-driven 8x8 text renderer into the framebuffer
module vga_text_ctrl
  import vga_pkg::*;
#(
  parameter int CLR_PIX = H_PIX * V_PIX
)
(
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_char,
  input  logic [6:0]  cmd_col,
  input  logic [5:0]  cmd_row,
  output logic [9:0]  font_addr,
  input  logic [7:0]  font_data,
  output logic        fb_we,
  output logic [17:0] fb_addr,
  output logic [7:0]  fb_wdata,
  output logic        busy,
  output logic        err,
  output logic [6:0]  cur_col,
  output logic [5:0]  cur_row
);

  localparam logic [17:0] ROW_STEP = 18'(H_PIX - CHAR_W + 1);
  localparam logic [17:0] CLR_LAST = 18'(CLR_PIX - 1);
  localparam logic [8:0]  FONT_END = 9'(int'(FONT_FIRST) + FONT_NUM);

  state_e      r_state, w_next;
  logic [6:0]  r_glyph;
  logic [2:0]  r_grow;
  logic [2:0]  r_px;
  logic [7:0]  r_sh;
  logic [17:0] r_addr;
  logic        r_err;
  logic        r_adv;
  logic [6:0]  r_col;
  logic [5:0]  r_row;

  logic        w_accept, w_is_put, w_use_cur, w_pos_ok, w_char_ok;
  logic [6:0]  w_col, w_row_dummy_unused_guard;
  logic [5:0]  w_row, w_row_next;
  logic [6:0]  w_glyph;
  logic [17:0] w_base;

  assign w_row_dummy_unused_guard = 7'd0;

  assign w_accept  = cmd_valid && (r_state == ST_IDLE);
  assign w_is_put  = (cmd_op == OP_PUTC_AT) || (cmd_op == OP_PUTC_CUR);
  assign w_use_cur = (cmd_op == OP_PUTC_CUR);
  assign w_col     = w_use_cur ? r_col : cmd_col;
  assign w_row     = w_use_cur ? r_row : cmd_row;
  assign w_pos_ok  = (w_col < COLS) && (w_row < ROWS);
  assign w_char_ok = (cmd_char >= FONT_FIRST) && ({1'b0, cmd_char} < FONT_END);
  assign w_glyph   = w_char_ok ? (cmd_char[6:0] - FONT_FIRST[6:0]) : 7'd0;
  assign w_row_next = (r_row == ROWS - 6'd1) ? 6'd0 : r_row + 6'd1;

  vga_char_addr u_char_addr (
    .i_col  (w_col),
    .i_row  (w_row),
    .o_base (w_base)
  );

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign fb_we     = (r_state == ST_DRAW) || (r_state == ST_CLR);
  assign fb_addr   = r_addr;
  assign fb_wdata  = ((r_state == ST_DRAW) && r_sh[7]) ? FG : BG;
  assign font_addr = {r_glyph, r_grow};
  assign err       = r_err;
  assign cur_col   = r_col;
  assign cur_row   = r_row;

  // Next-state: 8 glyph rows of fetch/latch/draw, or a linear clear sweep
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_is_put && w_pos_ok) w_next = ST_FETCH;
          else if (cmd_op == OP_CLEAR) w_next = ST_CLR;
        end
      end
      ST_FETCH: w_next = ST_LATCH;
      ST_LATCH: w_next = ST_DRAW;
      ST_DRAW: begin
        if (r_px == 3'd7) w_next = (r_grow == 3'd7) ? ST_DONE : ST_FETCH;
      end
      ST_DONE: w_next = ST_IDLE;
      ST_CLR: begin
        if (r_addr == CLR_LAST) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register plus address, glyph shifter and cursor datapath
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_glyph <= 7'd0;
      r_grow  <= 3'd0;
      r_px    <= 3'd0;
      r_sh    <= 8'd0;
      r_addr  <= 18'd0;
      r_err   <= 1'b0;
      r_adv   <= 1'b0;
      r_col   <= 7'd0;
      r_row   <= 6'd0;
    end else begin
      r_state <= w_next;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_err   <= w_is_put && (!w_pos_ok || !w_char_ok);
            r_glyph <= w_glyph;
            r_grow  <= 3'd0;
            r_px    <= 3'd0;
            r_adv   <= w_use_cur;
            r_addr  <= (cmd_op == OP_CLEAR) ? 18'd0 : w_base;
            if (cmd_op == OP_NEWLINE) begin
              r_col <= 7'd0;
              r_row <= w_row_next;
            end
          end
        end
        ST_LATCH: r_sh <= font_data;
        ST_DRAW: begin
          r_sh <= {r_sh[6:0], 1'b0};
          r_px <= r_px + 3'd1;
          if (r_px == 3'd7) begin
            r_addr <= r_addr + ROW_STEP;
            r_grow <= r_grow + 3'd1;
          end else begin
            r_addr <= r_addr + 18'd1;
          end
        end
        ST_DONE: begin
          if (r_adv) begin
            if (r_col == COLS - 7'd1) begin
              r_col <= 7'd0;
              r_row <= w_row_next;
            end else begin
              r_col <= r_col + 7'd1;
            end
          end
        end
        ST_CLR: begin
          r_addr <= r_addr + 18'd1;
          if (r_addr == CLR_LAST) begin
            r_col <= 7'd0;
            r_row <= 6'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_text_ctrl.sv
// tb/tb_vga_text_ctrl.sv - self-checking bench for vga_text_ctrl
module tb_vga_text_ctrl;

  localparam int CLR_PIX = 2048;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [7:0]  cmd_char = 8'd0;
  logic [6:0]  cmd_col = 7'd0;
  logic [5:0]  cmd_row = 6'd0;
  logic [9:0]  font_addr;
  logic [7:0]  font_data = 8'd0;
  logic        fb_we;
  logic [17:0] fb_addr;
  logic [7:0]  fb_wdata;
  logic        busy;
  logic        err;
  logic [6:0]  cur_col;
  logic [5:0]  cur_row;

  vga_text_ctrl #(.CLR_PIX(CLR_PIX)) dut (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_char  (cmd_char),
    .cmd_col   (cmd_col),
    .cmd_row   (cmd_row),
    .font_addr (font_addr),
    .font_data (font_data),
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_wdata  (fb_wdata),
    .busy      (busy),
    .err       (err),
    .cur_col   (cur_col),
    .cur_row   (cur_row)
  );

  always #5 pclk = ~pclk;

  logic [7:0] rom [0:1023];
  always @(posedge pclk) font_data <= rom[font_addr];

  int n_chk = 0;
  int n_pass = 0;
  int mpos = 0;
  int wr_a[$];
  int wr_d[$];
  int fa_q[$];
  int g_err_cnt, g_last_we, g_ready_at;

  typedef struct {
    string      nm;
    logic [1:0] op;
    int         ch;
    int         col;
    int         row;
    bit         e_err;
    bit         e_draw;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic bit m_char_ok(input int ch);
    return (ch >= 32) && (ch < 128);
  endfunction

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] ch, input logic [6:0] col,
                         input logic [5:0] row, input int max_cyc);
    int w;
    w = 0;
    @(negedge pclk);
    while (!cmd_ready && w < 5000) begin
      @(negedge pclk);
      w++;
    end
    if (w >= 5000) chk("idle before command", 0, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_char  = ch;
    cmd_col   = col;
    cmd_row   = row;
    @(posedge pclk);
    #1;
    cmd_valid = 1'b0;
    wr_a.delete();
    wr_d.delete();
    fa_q.delete();
    g_err_cnt  = 0;
    g_last_we  = -1;
    g_ready_at = -1;
    for (int n = 1; n <= max_cyc; n++) begin
      @(negedge pclk);
      if (fb_we) begin
        wr_a.push_back(int'(fb_addr));
        wr_d.push_back(int'(fb_wdata));
        g_last_we = n;
      end
      if (err) g_err_cnt++;
      if ((n % 10) == 1 && n <= 71) fa_q.push_back(int'(font_addr));
      if (cmd_ready) begin
        cmd_valid  = 1'b0;
        g_ready_at = n;
        break;
      end
      // a competing CLEAR held on the port while busy must be ignored
      if (n < 79) begin
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
      end else begin
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic exec(input string nm, input logic [1:0] op, input int ch, input int col,
                      input int row, input bit e_err, input bit e_draw);
    int c, r, g, bad, fbad, idx;
    logic [7:0] rb;
    c = (op == 2'd1) ? (mpos % 80) : col;
    r = (op == 2'd1) ? (mpos / 80) : row;
    g = m_char_ok(ch) ? (ch - 32) : 0;
    run_cmd(op, 8'(ch), 7'(col), 6'(row), 200);
    chk({nm, " err"}, g_err_cnt, e_err ? 1 : 0);
    chk({nm, " writes"}, wr_a.size(), e_draw ? 64 : 0);
    chk({nm, " ready"}, g_ready_at, e_draw ? 82 : 1);
    if (e_draw) begin
      bad = 0;
      for (int y = 0; y < 8; y++) begin
        rb = rom[g * 8 + y];
        for (int x = 0; x < 8; x++) begin
          idx = y * 8 + x;
          if (idx < wr_a.size()) begin
            if (wr_a[idx] != (r * 8 + y) * 640 + c * 8 + x) bad++;
            if (wr_d[idx] != (rb[7 - x] ? 255 : 0)) bad++;
          end
        end
      end
      fbad = 0;
      for (int k = 0; k < 8; k++)
        if (k >= fa_q.size() || fa_q[k] != g * 8 + k) fbad++;
      chk({nm, " pixels"}, bad, 0);
      chk({nm, " font_addr"}, fbad, 0);
      chk({nm, " last_we"}, g_last_we, 80);
    end
    if (op == 2'd1) mpos = (mpos + 1) % 4000;
    else if (op == 2'd2) mpos = ((mpos / 80 + 1) % 50) * 80;
    chk({nm, " cur_col"}, int'(cur_col), mpos % 80);
    chk({nm, " cur_row"}, int'(cur_row), mpos / 80);
  endtask

  initial begin
    int op, ch, col, row, bad;
    bit pos_ok, put;

    for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) rom[i] = 8'h00;

    vecs[0]  = '{"at_A_0_0",      2'd0, 8'h41,   0,  0, 1'b0, 1'b1};
    vecs[1]  = '{"at_sp_79_49",   2'd0, 8'h20,  79, 49, 1'b0, 1'b1};
    vecs[2]  = '{"at_col80",      2'd0, 8'h41,  80,  0, 1'b1, 1'b0};
    vecs[3]  = '{"at_row50",      2'd0, 8'h41,   0, 50, 1'b1, 1'b0};
    vecs[4]  = '{"at_ch05",       2'd0, 8'h05,   3,  2, 1'b1, 1'b1};
    vecs[5]  = '{"at_chff",       2'd0, 8'hff,   5,  5, 1'b1, 1'b1};
    vecs[6]  = '{"at_ch7f",       2'd0, 8'h7f,  10, 10, 1'b0, 1'b1};
    vecs[7]  = '{"at_bad_both",   2'd0, 8'h1f, 127, 63, 1'b1, 1'b0};
    vecs[8]  = '{"newline",       2'd2, 8'h41,   0,  0, 1'b0, 1'b0};
    vecs[9]  = '{"cur_ch80",      2'd1, 8'h80,   0,  0, 1'b1, 1'b1};
    vecs[10] = '{"at_ch20_1_1",   2'd0, 8'h20,   1,  1, 1'b0, 1'b1};

    repeat (3) @(negedge pclk);
    rst_n = 1'b1;
    @(negedge pclk);
    chk("reset cmd_ready", cmd_ready, 1);
    chk("reset fb_we", fb_we, 0);
    chk("reset fb_addr", int'(fb_addr), 0);
    chk("reset fb_wdata", int'(fb_wdata), 0);
    chk("reset font_addr", int'(font_addr), 0);
    chk("reset busy", busy, 0);
    chk("reset err", err, 0);
    chk("reset cur_col", int'(cur_col), 0);
    chk("reset cur_row", int'(cur_row), 0);

    for (int i = 0; i < 81; i++) exec("cur81", 2'd1, 65 + i % 26, 0, 0, 1'b0, 1'b1);
    chk("after 81 putc col", int'(cur_col), 1);
    chk("after 81 putc row", int'(cur_row), 1);

    for (int i = 0; i < 48; i++) exec("nl48", 2'd2, 0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 80; i++) exec("wrap80", 2'd1, 48 + i % 10, 0, 0, 1'b0, 1'b1);
    chk("wrap col", int'(cur_col), 0);
    chk("wrap row", int'(cur_row), 0);

    foreach (vecs[i]) exec(vecs[i].nm, vecs[i].op, vecs[i].ch, vecs[i].col, vecs[i].row,
                           vecs[i].e_err, vecs[i].e_draw);

    for (int i = 0; i < 30; i++) begin
      op  = $urandom_range(0, 2);
      ch  = $urandom_range(0, 255);
      col = $urandom_range(0, 84);
      row = $urandom_range(0, 54);
      put = (op < 2);
      pos_ok = (op == 1) || (col < 80 && row < 50);
      exec("rand", 2'(op), ch, col, row, put && (!pos_ok || !m_char_ok(ch)), put && pos_ok);
    end

    exec("pre_clear", 2'd1, 8'h5a, 0, 0, 1'b0, 1'b1);
    run_cmd(2'd3, 8'd0, 7'd0, 6'd0, CLR_PIX + 50);
    bad = 0;
    foreach (wr_a[i]) if (wr_a[i] != i || wr_d[i] != 0) bad++;
    chk("clear writes", wr_a.size(), CLR_PIX);
    chk("clear contiguous bg", bad, 0);
    chk("clear ready", g_ready_at, CLR_PIX + 1);
    chk("clear last_we", g_last_we, CLR_PIX);
    chk("clear err", g_err_cnt, 0);
    mpos = 0;
    chk("clear cur_col", int'(cur_col), 0);
    chk("clear cur_row", int'(cur_row), 0);

    exec("pre_reset", 2'd1, 8'h33, 0, 0, 1'b0, 1'b1);
    @(negedge pclk);
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_char  = 8'h41;
    cmd_col   = 7'd2;
    cmd_row   = 6'd3;
    @(posedge pclk);
    #1;
    cmd_valid = 1'b0;
    repeat (30) @(negedge pclk);
    chk("midreset fb_we before", fb_we, 1);
    chk("midreset busy before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset fb_we", fb_we, 0);
    chk("midreset busy", busy, 0);
    chk("midreset cmd_ready", cmd_ready, 1);
    chk("midreset cur_col", int'(cur_col), 0);
    @(negedge pclk);
    #1 rst_n = 1'b1;
    mpos = 0;
    exec("after_reset", 2'd0, 8'h42, 2, 3, 1'b0, 1'b1);
    exec("after_reset_cur", 2'd1, 8'h43, 0, 0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
